// File: rtl/knights_pkg.sv
// knights_pkg: shared command encodings, response codes, scheduler states and knight move table.
package knights_pkg;
    localparam int         NUM_MOVES  = 24;
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [7:0] HDG_N      = 8'h00;
    localparam logic [7:0] HDG_W      = 8'h3F;
    localparam logic [7:0] HDG_S      = 8'h7F;
    localparam logic [7:0] HDG_E      = 8'hBF;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_MOVE  = 8'h5A;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } delta_t;

    function automatic delta_t move_delta(input logic [2:0] b);
        case (b)
            3'd0:    move_delta = '{ 3'sd1,  3'sd2};
            3'd1:    move_delta = '{-3'sd1,  3'sd2};
            3'd2:    move_delta = '{-3'sd2,  3'sd1};
            3'd3:    move_delta = '{-3'sd2, -3'sd1};
            3'd4:    move_delta = '{-3'sd1, -3'sd2};
            3'd5:    move_delta = '{ 3'sd1, -3'sd2};
            3'd6:    move_delta = '{ 3'sd2, -3'sd1};
            default: move_delta = '{ 3'sd2,  3'sd1};
        endcase
    endfunction
endpackage

// File: rtl/knight_move_decode.sv
// knight_move_decode: turns a one-hot knight move into its vertical and horizontal leg commands.
module knight_move_decode
    import knights_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);
    logic [2:0] w_bit;
    delta_t     w_d;
    logic [2:0] w_vsq;
    logic [2:0] w_hsq;

    // Descending scan leaves the lowest set bit; an all-zero move falls back to b0.
    always_comb begin
        w_bit = '0;
        for (int i = 7; i >= 0; i--)
            if (move[i]) w_bit = 3'(i);
    end

    assign w_d      = move_delta(w_bit);
    assign w_vsq    = w_d.dy[2] ? -w_d.dy : w_d.dy;
    assign w_hsq    = w_d.dx[2] ? -w_d.dx : w_d.dx;
    assign vert_cmd = {OP_MOVE,    w_d.dy[2] ? HDG_S : HDG_N, 1'b0, w_vsq};
    assign horz_cmd = {OP_FANFARE, w_d.dx[2] ? HDG_W : HDG_E, 1'b0, w_hsq};
endmodule

// File: rtl/tour_cmd_sched.sv
// tour_cmd_sched: muxes cmd_proc between UART passthrough and replay of a solved knight's tour,
// issuing each move as a vertical then a horizontal leg and choosing the host response byte.
module tour_cmd_sched
    import knights_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        tour_done,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);
    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t      r_state;
    logic [4:0]  r_mv_indx;
    logic [15:0] w_vert_cmd;
    logic [15:0] w_horz_cmd;
    logic        w_idle;
    logic        w_last;

    knight_move_decode u_dec (
        .move     (move),
        .vert_cmd (w_vert_cmd),
        .horz_cmd (w_horz_cmd)
    );

    // A send_resp coinciding with clr_cmd_rdy in VERT belongs to the UART era and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= '0;
        end else begin
            case (r_state)
                IDLE:    if (tour_done) begin
                             r_state   <= VERT;
                             r_mv_indx <= '0;
                         end
                VERT:    if (clr_cmd_rdy) r_state <= WAIT_V;
                WAIT_V:  if (send_resp) r_state <= HORZ;
                HORZ:    if (clr_cmd_rdy) r_state <= WAIT_H;
                WAIT_H:  if (send_resp) begin
                             r_state   <= w_last ? IDLE : VERT;
                             r_mv_indx <= w_last ? '0 : r_mv_indx + 5'd1;
                         end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_idle           = r_state == IDLE;
    assign w_last           = r_mv_indx == LAST_INDX;
    assign mv_indx          = r_mv_indx;
    assign cmd              = w_idle ? cmd_UART :
                              (r_state == HORZ || r_state == WAIT_H) ? w_horz_cmd : w_vert_cmd;
    assign cmd_rdy          = w_idle ? cmd_rdy_UART : (r_state == VERT || r_state == HORZ);
    assign clr_cmd_rdy_UART = w_idle & clr_cmd_rdy;
    assign resp             = (w_idle || (r_state == WAIT_H && w_last)) ? RESP_DONE : RESP_MOVE;
endmodule

// File: tb/tb_tour_cmd_sched.sv
// tb_tour_cmd_sched: directed self-checking bench for the tour command scheduler.
module tb_tour_cmd_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_UART = '0;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic        tour_done = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic        use_tbl = 1'b0;
    logic [7:0]  move_drv = '0;
    logic [7:0]  mv_tbl [32];
    int          total = 0;
    int          passed = 0;
    int          n_cmds = 0;

    assign move = use_tbl ? mv_tbl[mv_indx] : move_drv;

    tour_cmd_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .tour_done        (tour_done),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Hand-derived leg commands for each decoded move bit.
    function automatic logic [15:0] exp_v(input int b);
        case (b)
            0, 1:    return 16'h2002;
            2, 7:    return 16'h2001;
            3, 6:    return 16'h27F1;
            default: return 16'h27F2;
        endcase
    endfunction

    function automatic logic [15:0] exp_h(input int b);
        case (b)
            0, 5:    return 16'h3BF1;
            1, 4:    return 16'h33F1;
            2, 3:    return 16'h33F2;
            default: return 16'h3BF2;
        endcase
    endfunction

    function automatic int mbit(input int i);
        return (i == 7) ? 2 : (i == 15) ? 0 : i % 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_tour_done();
        tour_done = 1'b1;
        tick();
        tour_done = 1'b0;
    endtask

    task automatic leg(input logic [15:0] ec, input logic [7:0] er, input string nm);
        int n = 0;
        while (!cmd_rdy && n < 20) begin
            tick();
            n++;
        end
        total++; if (cmd_rdy !== 1'b1) $display("FAIL %s cmd_rdy timeout got %b exp 1", nm, cmd_rdy); else passed++;
        total++; if (cmd !== ec) $display("FAIL %s cmd got %h exp %h", nm, cmd, ec); else passed++;
        clr_cmd_rdy = 1'b1;
        #1;
        total++; if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL %s clr_cmd_rdy_UART got %b exp 0", nm, clr_cmd_rdy_UART); else passed++;
        n_cmds++;
        tick();
        clr_cmd_rdy = 1'b0;
        total++; if (cmd_rdy !== 1'b0) $display("FAIL %s wait cmd_rdy got %b exp 0", nm, cmd_rdy); else passed++;
        send_resp = 1'b1;
        #1;
        total++; if (resp !== er) $display("FAIL %s resp got %h exp %h", nm, resp, er); else passed++;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic test_reset();
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1;
        #3;
        total++; if (mv_indx !== 5'd0) $display("FAIL reset mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (cmd !== 16'h1234) $display("FAIL reset cmd got %h exp 1234", cmd); else passed++;
        total++; if (cmd_rdy !== 1'b1) $display("FAIL reset cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        total++; if (resp !== 8'hA5) $display("FAIL reset resp got %h exp a5", resp); else passed++;
        rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        cmd_UART = 16'h2004;
        cmd_rdy_UART = 1'b1;
        #1;
        total++; if (cmd_rdy !== 1'b1) $display("FAIL pass cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        total++; if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL pass clr_idle got %b exp 0", clr_cmd_rdy_UART); else passed++;
        clr_cmd_rdy = 1'b1;
        #1;
        total++; if (cmd !== 16'h2004) $display("FAIL pass cmd got %h exp 2004", cmd); else passed++;
        total++; if (clr_cmd_rdy_UART !== 1'b1) $display("FAIL pass clr_cmd_rdy_UART got %b exp 1", clr_cmd_rdy_UART); else passed++;
        total++; if (resp !== 8'hA5) $display("FAIL pass resp got %h exp a5", resp); else passed++;
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        total++; if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL pass clr_release got %b exp 0", clr_cmd_rdy_UART); else passed++;
    endtask

    task automatic test_single_move();
        use_tbl = 1'b0;
        move_drv = 8'h04;
        pulse_tour_done();
        total++; if (mv_indx !== 5'd0) $display("FAIL b2 mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (cmd_rdy !== 1'b1) $display("FAIL b2 cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        total++; if (cmd !== 16'h2001) $display("FAIL b2 vert cmd got %h exp 2001", cmd); else passed++;
        total++; if (resp !== 8'h5A) $display("FAIL b2 vert resp got %h exp 5a", resp); else passed++;
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        total++; if (cmd_rdy !== 1'b0) $display("FAIL b2 same_cycle cmd_rdy got %b exp 0", cmd_rdy); else passed++;
        tour_done = 1'b1;
        tick();
        tour_done = 1'b0;
        total++; if (mv_indx !== 5'd0) $display("FAIL b2 tour_done_ignored mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (cmd_rdy !== 1'b0) $display("FAIL b2 tour_done_ignored cmd_rdy got %b exp 0", cmd_rdy); else passed++;
        send_resp = 1'b1;
        #1;
        total++; if (resp !== 8'h5A) $display("FAIL b2 vert done resp got %h exp 5a", resp); else passed++;
        tick();
        send_resp = 1'b0;
        leg(16'h33F2, 8'h5A, "b2_horz");
        total++; if (mv_indx !== 5'd1) $display("FAIL b2 next mv_indx got %0d exp 1", mv_indx); else passed++;
        do_reset();
    endtask

    task automatic test_south_east();
        use_tbl = 1'b0;
        move_drv = 8'h40;
        pulse_tour_done();
        leg(16'h27F1, 8'h5A, "b6_vert");
        leg(16'h3BF2, 8'h5A, "b6_horz");
        do_reset();
    endtask

    task automatic test_full_tour();
        use_tbl = 1'b1;
        n_cmds = 0;
        pulse_tour_done();
        for (int i = 0; i < 24; i++) begin
            total++; if (mv_indx !== 5'(i)) $display("FAIL tour mv_indx got %0d exp %0d", mv_indx, i); else passed++;
            if (i == 5) begin
                cmd_UART = 16'h2ABC;
                cmd_rdy_UART = 1'b1;
            end
            leg(exp_v(mbit(i)), 8'h5A, $sformatf("tour%0d_vert", i));
            leg(exp_h(mbit(i)), (i == 23) ? 8'hA5 : 8'h5A, $sformatf("tour%0d_horz", i));
        end
        total++; if (n_cmds !== 48) $display("FAIL tour n_cmds got %0d exp 48", n_cmds); else passed++;
        total++; if (mv_indx !== 5'd0) $display("FAIL tour end mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (cmd_rdy !== 1'b1) $display("FAIL tour end cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        total++; if (cmd !== 16'h2ABC) $display("FAIL tour end cmd got %h exp 2abc", cmd); else passed++;
        total++; if (resp !== 8'hA5) $display("FAIL tour end resp got %h exp a5", resp); else passed++;
        clr_cmd_rdy = 1'b1;
        #1;
        total++; if (clr_cmd_rdy_UART !== 1'b1) $display("FAIL held uart clr got %b exp 1", clr_cmd_rdy_UART); else passed++;
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_reset_mid_tour();
        use_tbl = 1'b1;
        pulse_tour_done();
        for (int i = 0; i < 10; i++) begin
            leg(exp_v(mbit(i)), 8'h5A, $sformatf("rst%0d_vert", i));
            leg(exp_h(mbit(i)), 8'h5A, $sformatf("rst%0d_horz", i));
        end
        total++; if (mv_indx !== 5'd10) $display("FAIL rst pre mv_indx got %0d exp 10", mv_indx); else passed++;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        total++; if (cmd_rdy !== 1'b0) $display("FAIL rst wait_v cmd_rdy got %b exp 0", cmd_rdy); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (mv_indx !== 5'd0) $display("FAIL rst mid mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (resp !== 8'hA5) $display("FAIL rst mid resp got %h exp a5", resp); else passed++;
        cmd_rdy_UART = 1'b1;
        #1;
        total++; if (cmd_rdy !== 1'b1) $display("FAIL rst mid cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (cmd_rdy !== 1'b1) $display("FAIL rst idle cmd_rdy got %b exp 1", cmd_rdy); else passed++;
        cmd_rdy_UART = 1'b0;
        #1;
        total++; if (cmd_rdy !== 1'b0) $display("FAIL rst idle cmd_rdy_low got %b exp 0", cmd_rdy); else passed++;
        pulse_tour_done();
        total++; if (mv_indx !== 5'd0) $display("FAIL restart mv_indx got %0d exp 0", mv_indx); else passed++;
        total++; if (cmd !== exp_v(mbit(0))) $display("FAIL restart cmd got %h exp %h", cmd, exp_v(mbit(0))); else passed++;
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mv_tbl[i] = (i == 7) ? 8'h0C : (i == 15) ? 8'h00 : 8'(1 << (i % 8));
        test_reset();
        test_passthrough();
        test_single_move();
        test_south_east();
        test_full_tour();
        test_reset_mid_tour();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tour_cmd_sched.md
# tour_cmd_sched

Command scheduler between the BLE UART command path, the tour solver and `cmd_proc`. It passes host commands through to `cmd_proc` while idle. Once the solver reports a finished tour, it takes ownership of `cmd_proc` and replays the 24 solved knight moves. Each move is issued as a vertical leg then a horizontal leg. It also selects the response byte returned to the host after each completed move.

## Interface
- `NUM_MOVES`, 24: moves in a full 5x5 tour; last index is `NUM_MOVES-1`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_UART` in 16: command from the UART wrapper.
- `cmd_rdy_UART` in 1: UART command valid.
- `clr_cmd_rdy_UART` out 1: consume the UART command.
- `tour_done` in 1: single-cycle pulse; the solver has finished and its move list is valid.
- `move` in 8: one-hot knight move for `mv_indx`, from the solver.
- `mv_indx` out 5: index of the move currently being replayed.
- `cmd` out 16: command to `cmd_proc`.
- `cmd_rdy` out 1: `cmd` valid to `cmd_proc`.
- `clr_cmd_rdy` in 1: `cmd_proc` has accepted `cmd`.
- `send_resp` in 1: `cmd_proc` has completed the current command.
- `resp` out 8: response byte to the UART wrapper, sampled when `send_resp` is high.

## Operation
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: 0x2 = move, 0x3 = move with fanfare.
  - Headings: N = 0x00, W = 0x3F, S = 0x7F, E = 0xBF.
- Move decode, bit -> (dx, dy):
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
  - Decode uses the lowest set bit; 8'h00 decodes as b0 (unsupported input).
- Vertical leg: opcode 0x2, heading N if dy>0 else S, squares = |dy|.
- Horizontal leg: opcode 0x3, heading E if dx>0 else W, squares = |dx|.
- FSM states:
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp`=0xA5. On `tour_done` -> VERT with `mv_indx`=0.
  - VERT: `cmd`=vertical leg, `cmd_rdy`=1. On `clr_cmd_rdy` -> WAIT_V.
  - WAIT_V: `cmd_rdy`=0. On `send_resp` -> HORZ.
  - HORZ: `cmd`=horizontal leg, `cmd_rdy`=1. On `clr_cmd_rdy` -> WAIT_H.
  - WAIT_H: `cmd_rdy`=0.
    - On `send_resp` with `mv_indx`==NUM_MOVES-1 -> IDLE, `mv_indx` cleared to 0.
    - On `send_resp` otherwise -> VERT, `mv_indx`+1.
- Response selection:
  - `resp`=0x5A in VERT, WAIT_V and HORZ.
  - In WAIT_H, `resp`=0xA5 if `mv_indx`==NUM_MOVES-1, else 0x5A.
  - Each `send_resp` therefore carries the correct code; the vertical-leg completion also reports 0x5A.
- Outside IDLE:
  - UART commands are held off: `clr_cmd_rdy_UART`=0 and `cmd_rdy_UART` is ignored. They are consumed after return to IDLE.
  - `tour_done` is ignored.
- Reset: state=IDLE, `mv_indx`=0. Outputs then follow the IDLE mux: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `resp`=0xA5. Reset mid-tour abandons the tour.

## Timing
- State and `mv_indx` are registered; all outputs are combinational from state, `mv_indx`, `move` and the UART inputs.
- `tour_done` at edge k puts VERT and `cmd_rdy`=1 in cycle k+1.
- `mv_indx` updates on the same edge that enters VERT. `move` must be valid by the following cycle, and is sampled only in VERT/HORZ.
- `cmd` stays stable while `cmd_rdy`=1.
- `clr_cmd_rdy` and `send_resp` arriving in the same cycle in VERT: only `clr_cmd_rdy` is acted on. The `send_resp` is treated as the UART-era response and dropped.
- `mv_indx` width: 5 bits. It never exceeds NUM_MOVES-1 and does not wrap.

## Structure
- Shared package `knights_pkg`: opcode constants, heading constants, response codes (RESP_DONE=0xA5, RESP_MOVE=0x5A), state enum, and the move-to-(dx,dy) table.
- One sub-module: `knight_move_decode`. Combinational; `move` in, vertical and horizontal commands out.

## Test plan
- Idle passthrough: present `cmd_UART`=0x2004 with `cmd_rdy_UART`=1; pulse `clr_cmd_rdy` -> `cmd`=0x2004, `clr_cmd_rdy_UART` pulses, `resp`=0xA5.
- Single move b2: pulse `tour_done` with `move`=0x04 -> `cmd`=0x2001 (N, 1 square), then 0x33F2 (W, 2 squares) after `clr_cmd_rdy` and `send_resp`; `resp`=0x5A at both `send_resp`.
- Full tour: model `cmd_proc` handshakes for 24 moves -> 48 issued commands, `mv_indx` 0..23; last `send_resp` sees 0xA5, then state returns to IDLE with `mv_indx`=0.
- Held-off UART: assert `cmd_rdy_UART` at move 5 -> `clr_cmd_rdy_UART` stays 0 until the tour ends, then the command passes through.
- Reset at move 10 in WAIT_V -> IDLE, `mv_indx`=0, `cmd_rdy` follows `cmd_rdy_UART`; a new `tour_done` restarts at index 0.
- Southern/eastern legs: `move`=0x40 -> `cmd`=0x27F1 (S, 1 square), then 0x3BF2 (E, 2 squares).
